branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Front-end counterpart to the EX-stage branch comparator. It predicts conditional-branch direction and target in IF, using a direct-mapped BTB with 2-bit saturating counters.
- It consumes the resolved branch outcome `br` from EX, together with the target and the prediction that was carried down the pipe.
- It updates the tables and raises mispredict/redirect for the PC mux and the IF/ID and ID/EX flush logic.

Parameters:
- IDX_W, 6: index width; table depth is 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- CNT_INIT, 2'b01: counter value written on reset (weakly not-taken).
- ALLOC_CNT, 2'b10: counter value written on allocation (weakly taken).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_pc  in  32  PC being fetched
- pred_taken  out  1  IF prediction: branch taken
- pred_target  out  32  predicted target; 0 when pred_taken=0
- if_npc  out  32  pred_taken ? pred_target : if_pc+4
- ex_valid  in  1  EX stage holds a live, unflushed instruction
- ex_is_br  in  1  EX instruction is a conditional branch (br_type != 0)
- ex_pc  in  32  PC of the EX instruction
- ex_br  in  1  resolved outcome from the branch comparator
- ex_target  in  32  computed branch target (pc + imm)
- ex_pred_taken  in  1  prediction piped from IF
- ex_pred_target  in  32  predicted target piped from IF
- mispredict  out  1  redirect and flush required
- redirect_pc  out  32  correct next PC

Behaviour:
Tables (IDX_W bits each dimension, TAG = pc[31:IDX_W+2]):
- Per entry: valid, tag, target[31:0], cnt[1:0].
- Tables are registers.

Reset:
- Async on rst: all valid=0 and all cnt=CNT_INIT. Tag and target need not be reset.
- While rst is high the outputs are:
  - pred_taken=0
  - pred_target=0
  - if_npc=if_pc+4
  - mispredict=0
  - redirect_pc=ex_pc+4

Lookup (combinational, 0-cycle latency):
- hit = valid[idx] & (tag[idx]==if_pc TAG).
- pred_taken = hit & cnt[idx][1].
- pred_target = pred_taken ? target[idx] : 0.

Resolution (combinational):
- upd = ex_valid & ex_is_br & ~rst.
- mispredict = upd & ((ex_br != ex_pred_taken) | (ex_br & ex_pred_taken & ex_pred_target != ex_target)).
- redirect_pc = ex_br ? ex_target : ex_pc+4. It is valid whenever mispredict=1 and don't-care otherwise.

Update (posedge clk, when upd=1; entry selected by ex_pc index and tag):
- Taken, hit: cnt = min(cnt+1, 3); target = ex_target.
- Taken, miss: allocate, overwriting any occupant: valid=1, tag written, target=ex_target, cnt=ALLOC_CNT.
- Not taken, hit: cnt = max(cnt-1, 0).
- Not taken, miss: no change. Not-taken branches never allocate.
- upd=0 (bubble, flushed slot, non-branch): no state change.

Boundary conditions:
- Counters saturate at 0 and 3 with no wrap-around.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents; there is no bypass. The new value is visible on the next cycle.
- Aliasing: a different tag at the same index is a miss for lookup. A taken update replaces the entry.
- Reset asserted mid-operation clears valid bits immediately. Any in-flight update on that edge is discarded.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs stat_br[31:0] and stat_miss[31:0].
  - They increment on each clock edge with upd=1, and with upd & mispredict respectively.
  - Both wrap modulo 2^32 and reset to 0 asynchronously.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0, if_npc=0x104. Repeat for random PCs: never taken.
2. EX beq at ex_pc=0x100, ex_br=1, ex_target=0x80, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80, if_npc=0x80.
3. Four further taken updates at 0x100 -> cnt saturates at 3. Then one not-taken -> still predicts taken (cnt=2). A second not-taken -> pred_taken=0. That second update's mispredict is 1 with redirect_pc=0x104.
4. Alias: entry for 0x100 is valid. Taken branch at 0x100+4·2^IDX_W=0x200 (IDX_W=6) to 0x40 -> lookup 0x100 misses, lookup 0x200 hits with target 0x40. A not-taken miss at 0x300 leaves all entries unchanged.
5. Same-cycle: if_pc=ex_pc=0x100, first taken update -> pred_taken=0 that cycle and 1 the following cycle. With ex_valid=0 or ex_is_br=0 -> mispredict=0 and tables unchanged.
6. Predicted taken to 0x80 but ex_target=0x90, ex_br=1 -> mispredict=1, redirect_pc=0x90, entry target updated to 0x90. Assert rst mid-run -> all lookups miss immediately. With BP_STATS_EN, after 10 branches with 3 mispredicts -> stat_br=10, stat_miss=3.

Source files
------------

// File: rtl/branch_predictor.sv
// Purpose: IF-stage direction/target predictor (direct-mapped BTB, 2-bit counters) with EX-stage resolution and update.
// Latency: lookup and mispredict/redirect are combinational (0 cycles); table updates are visible the cycle after the edge.
// Backpressure: none; one lookup and at most one update per cycle. The optional BP_STATS_EN macro adds stat_br/stat_miss counters.
module branch_predictor #(
    parameter int         IDX_W     = 6,
    parameter logic [1:0] CNT_INIT  = 2'b01,
    parameter logic [1:0] ALLOC_CNT = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] if_npc,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic [31:0] ex_pc,
    input  logic        ex_br,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_br,
    output logic [31:0] stat_miss
`endif
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [1:0]       cnt_q    [DEPTH];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] e_tag;
    logic             f_hit;
    logic             e_hit;
    logic             upd;
    logic             unused_pc_lsbs;

    assign f_idx = if_pc[IDX_W+1:2];
    assign f_tag = if_pc[31:IDX_W+2];
    assign e_idx = ex_pc[IDX_W+1:2];
    assign e_tag = ex_pc[31:IDX_W+2];

    // Byte offset within the instruction word plays no part in indexing or tagging.
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign upd   = ex_valid & ex_is_br & ~rst;

    // IF lookup: reads pre-update table contents, no bypass from the EX update.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = 32'd0;
        if (!rst && f_hit && cnt_q[f_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = target_q[f_idx];
        end
        if_npc = pred_taken ? pred_target : (if_pc + 32'd4);
    end

    // EX resolution: wrong direction, or right direction (taken) with wrong target.
    always_comb begin
        mispredict  = upd & ((ex_br != ex_pred_taken) |
                             (ex_br & ex_pred_taken & (ex_pred_target != ex_target)));
        redirect_pc = (ex_br && !rst) ? ex_target : (ex_pc + 32'd4);
    end

    // Valid bits and counters: async clear, then train on each resolved branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (upd) begin
            if (ex_br) begin
                if (e_hit) begin
                    if (cnt_q[e_idx] != 2'b11) begin
                        cnt_q[e_idx] <= cnt_q[e_idx] + 2'b01;
                    end
                end else begin
                    valid_q[e_idx] <= 1'b1;
                    cnt_q[e_idx]   <= ALLOC_CNT;
                end
            end else if (e_hit && (cnt_q[e_idx] != 2'b00)) begin
                cnt_q[e_idx] <= cnt_q[e_idx] - 2'b01;
            end
        end
    end

    // Tag/target payload: written on every taken branch (refresh on hit, replace on miss).
    always_ff @(posedge clk) begin
        if (upd && ex_br) begin
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= ex_target;
        end
    end

`ifdef BP_STATS_EN
    // Branch and mispredict event counters, free-running modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br   <= 32'd0;
            stat_miss <= 32'd0;
        end else if (upd) begin
            stat_br <= stat_br + 32'd1;
            if (mispredict) begin
                stat_miss <= stat_miss + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Purpose: randomized and directed stimulus for branch_predictor against a behavioural BTB model.
// Latency: combinational outputs sampled 2ns after inputs change; model updated on each rising edge.
// Backpressure: not applicable; one transaction per cycle.
module tb_branch_predictor;

    localparam int IDX_W = 6;
    localparam int DEPTH = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] if_npc;
    logic        ex_valid;
    logic        ex_is_br;
    logic [31:0] ex_pc;
    logic        ex_br;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_miss;
`endif

    branch_predictor #(.IDX_W(IDX_W), .CNT_INIT(2'b01), .ALLOC_CNT(2'b10)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .if_npc         (if_npc),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_pc          (ex_pc),
        .ex_br          (ex_br),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_br        (stat_br),
        .stat_miss      (stat_miss)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one slot per word-address modulo DEPTH, holding the full branch word address.
    bit          m_valid [DEPTH];
    logic [31:0] m_wpc   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_cnt   [DEPTH];
    logic [31:0] m_br;
    logic [31:0] m_miss;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit mhit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_wpc[slot(pc)] == (pc >> 2));
    endfunction

    task automatic mlook(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        tk = mhit(pc) && (m_cnt[slot(pc)] >= 2);
        tg = tk ? m_tgt[slot(pc)] : 32'd0;
    endtask

    task automatic check_stats();
`ifdef BP_STATS_EN
        chk("stat_br", stat_br, m_br);
        chk("stat_miss", stat_miss, m_miss);
`endif
    endtask

    // One cycle: drive inputs, check combinational outputs against the model, then clock the model.
    task automatic apply(input logic v, input logic b, input logic [31:0] fpc, input logic [31:0] epc,
                         input logic br, input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
        logic        mtk;
        logic [31:0] mtg;
        bit          u;
        bit          mp;
        bit          h;
        int          s;
        if_pc = fpc; ex_valid = v; ex_is_br = b; ex_pc = epc;
        ex_br = br; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
        #2;
        mlook(fpc, mtk, mtg);
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, mtk});
        chk("pred_target", pred_target, mtg);
        chk("if_npc", if_npc, mtk ? mtg : fpc + 32'd4);
        u  = v && b;
        mp = u && ((br != pt) || (br && pt && (ptg != tgt)));
        chk("mispredict", {31'd0, mispredict}, {31'd0, mp});
        if (mp) chk("redirect_pc", redirect_pc, br ? tgt : epc + 32'd4);
        @(posedge clk);
        if (u) begin
            s = slot(epc);
            h = mhit(epc);
            m_br++;
            if (mp) m_miss++;
            if (br) begin
                if (h) m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
                else begin
                    m_valid[s] = 1'b1;
                    m_wpc[s]   = epc >> 2;
                    m_cnt[s]   = 2;
                end
                m_tgt[s] = tgt;
            end else if (h) begin
                m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
            end
        end
        #1;
    endtask

    // Bubble cycle with a fixed expectation on the fetch-side outputs.
    task automatic probe(input string tag, input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tg);
        if_pc = pc; ex_valid = 1'b0; ex_is_br = 1'b0;
        #2;
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        chk({tag, "_target"}, pred_target, exp_tg);
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges with a live taken branch in EX; that branch must be discarded.
    task automatic mid_reset(input logic [31:0] fpc, input logic [31:0] epc);
        if_pc = fpc; ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = epc;
        ex_br = 1'b1; ex_target = 32'h0000_0abc; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
        rst = 1'b1;
        #2;
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        chk("rst_if_npc", if_npc, fpc + 32'd4);
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, epc + 32'd4);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_stats();
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom % 8)
            0: return 32'h0000_0100;
            1: return 32'h0000_0200;
            2: return 32'h0000_0300;
            3: return 32'h0000_0104;
            4: return 32'h0000_1000;
            5: return 32'h0000_0204;
            6: return {$urandom, 2'b00} & 32'h0000_0ffc;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        pt;
        logic [31:0] ptg;
        logic [31:0] fpc;
        logic [31:0] epc;

        model_reset();
        rst = 1'b1;
        if_pc = 32'h100; ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = 32'h100;
        ex_br = 1'b1; ex_target = 32'h80; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
        #2;
        chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset_if_npc", if_npc, 32'h104);
        chk("reset_mispredict", {31'd0, mispredict}, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'h104);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_stats();

        // Cold tables never predict taken.
        probe("cold", 32'h100, 1'b0, 32'd0);
        for (int i = 0; i < 8; i++) apply(1'b0, 1'b0, pick_pc(), 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);

        // First taken branch at 0x100 allocates; same-cycle lookup still misses.
        apply(1'b1, 1'b1, 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        probe("alloc", 32'h100, 1'b1, 32'h80);
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b1, 32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        apply(1'b1, 1'b1, 32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        probe("sat_nt1", 32'h100, 1'b1, 32'h80);
        apply(1'b1, 1'b1, 32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        probe("sat_nt2", 32'h100, 1'b0, 32'd0);

        // Bubbles and non-branches leave the tables alone.
        apply(1'b0, 1'b1, 32'h100, 32'h100, 1'b1, 32'h44, 1'b0, 32'd0);
        apply(1'b1, 1'b0, 32'h100, 32'h100, 1'b1, 32'h44, 1'b0, 32'd0);

        // Aliasing at index 0: 0x200 replaces 0x100; not-taken miss at 0x300 changes nothing.
        apply(1'b1, 1'b1, 32'h200, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        apply(1'b1, 1'b1, 32'h200, 32'h200, 1'b1, 32'h40, 1'b0, 32'd0);
        probe("alias_old", 32'h100, 1'b0, 32'd0);
        probe("alias_new", 32'h200, 1'b1, 32'h40);
        apply(1'b1, 1'b1, 32'h300, 32'h300, 1'b0, 32'h60, 1'b0, 32'd0);
        probe("alias_nt", 32'h200, 1'b1, 32'h40);

        // Right direction, wrong target: redirect to the real target and retrain.
        apply(1'b1, 1'b1, 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        apply(1'b1, 1'b1, 32'h100, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        probe("retarget", 32'h100, 1'b1, 32'h90);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            fpc = pick_pc();
            epc = pick_pc();
            if ($urandom % 2) mlook(epc, pt, ptg);
            else begin
                pt  = 1'($urandom % 2);
                ptg = pick_pc();
            end
            apply(1'($urandom % 8 != 0), 1'($urandom % 4 != 0), fpc, epc,
                  1'($urandom % 3 != 0), pick_pc(), pt, ptg);
            if (i % 100 == 99) check_stats();
        end
        check_stats();

        // Reset in the middle of a warm run: every lookup misses immediately.
        mid_reset(32'h100, 32'h200);
        probe("post_rst_a", 32'h100, 1'b0, 32'd0);
        probe("post_rst_b", 32'h200, 1'b0, 32'd0);

        // Ten branches, three of them mispredicted.
        for (int i = 0; i < 10; i++) begin
            epc = 32'h400 + 32'(4 * (i % 3));
            mlook(epc, pt, ptg);
            if (i == 2 || i == 5 || i == 8) apply(1'b1, 1'b1, epc, epc, ~pt, 32'h800, pt, ptg);
            else if (pt) apply(1'b1, 1'b1, epc, epc, 1'b1, ptg, pt, ptg);
            else apply(1'b1, 1'b1, epc, epc, 1'b0, 32'h800, pt, ptg);
        end
        check_stats();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
